alu_ctl_mdu: RTL and testbench

- Next-generation EX-stage ALU controller for the pipelined MIPS core.
- Decodes ALUOp/Funct into a registered 4-bit ALUOperation, covering an extended R-type set.
- Owns an iterative multiply/divide unit (MDU) with HI/LO registers, a Busy/Stall handshake to the hazard unit, and registered mfhi/mflo readback.

---
 rtl/alu_ctl_mdu_if.sv | 29 ++
 rtl/alu_ctl_mdu.sv | 201 ++++++++++++++++++++
 tb/tb_alu_ctl_mdu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctl_mdu_if.sv
// EX-stage ALU control / MDU bus between the pipeline and alu_ctl_mdu.
// Flush is present only when MDU_FLUSH_EN is defined.
interface alu_ctl_mdu_if #(parameter int unsigned WIDTH = 32);
    logic             In_Valid;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUOperation;
    logic             Illegal;
    logic             Stall;
    logic             Busy;
    logic [WIDTH-1:0] MduResult;
    logic             MduValid;
    logic             DivZero;
`ifdef MDU_FLUSH_EN
    logic             Flush;

    modport master (output In_Valid, ALUOp, Funct, A, B, Flush,
                    input  ALUOperation, Illegal, Stall, Busy, MduResult, MduValid, DivZero);
    modport slave  (input  In_Valid, ALUOp, Funct, A, B, Flush,
                    output ALUOperation, Illegal, Stall, Busy, MduResult, MduValid, DivZero);
`else
    modport master (output In_Valid, ALUOp, Funct, A, B,
                    input  ALUOperation, Illegal, Stall, Busy, MduResult, MduValid, DivZero);
    modport slave  (input  In_Valid, ALUOp, Funct, A, B,
                    output ALUOperation, Illegal, Stall, Busy, MduResult, MduValid, DivZero);
`endif
endinterface

// File: rtl/alu_ctl_mdu.sv
// EX-stage ALU operation decoder with an iterative multiply/divide unit and HI/LO.
// Optional MDU abort input Flush is enabled by defining MDU_FLUSH_EN.
module alu_ctl_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctl_mdu_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] opb, a_raw, hi, lo, mdu_result;
    logic             neg_q, neg_r, b_zero, is_div;
    logic [3:0]       alu_op;
    logic             illegal, busy, mdu_valid, div_zero;

    logic       flush, valid, stall, accept;
    logic [3:0] op_c;
    logic       illegal_c, mdu_c, start_c, mfhi_c, mflo_c;

`ifdef MDU_FLUSH_EN
    assign flush = bus.Flush;
`else
    assign flush = 1'b0;
`endif
    assign valid  = bus.In_Valid & ~flush;
    assign stall  = valid & busy & mdu_c;
    assign accept = valid & ~stall;

    // Instruction decode; unknown encodings resolve to 0000 with Illegal
    always_comb begin
        op_c      = 4'b0000;
        illegal_c = 1'b0;
        mdu_c     = 1'b0;
        start_c   = 1'b0;
        mfhi_c    = 1'b0;
        mflo_c    = 1'b0;
        case (bus.ALUOp)
            2'b00: op_c = 4'b0010;
            2'b01: op_c = 4'b0110;
            2'b10: begin
                case (bus.Funct)
                    6'd32: op_c = 4'b0010;
                    6'd34: op_c = 4'b0110;
                    6'd36: op_c = 4'b0000;
                    6'd37: op_c = 4'b0001;
                    6'd38: op_c = 4'b0011;
                    6'd39: op_c = 4'b1100;
                    6'd42: op_c = 4'b0111;
                    6'd43: op_c = 4'b1111;
                    6'd24, 6'd25, 6'd26, 6'd27: begin
                        mdu_c   = 1'b1;
                        start_c = 1'b1;
                    end
                    6'd16: begin
                        mdu_c  = 1'b1;
                        mfhi_c = 1'b1;
                    end
                    6'd18: begin
                        mdu_c  = 1'b1;
                        mflo_c = 1'b1;
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            default: illegal_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:        if (accept && start_c) state_next = bus.Funct[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV:  if (cnt == CNT_W'(1)) state_next = S_DONE;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
        if (flush && state != S_IDLE) state_next = S_IDLE;
    end

    // Operand magnitudes; odd Funct (multu/divu) is unsigned
    logic             sgn_c, sa_c, sb_c;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn_c = ~bus.Funct[0];
    assign sa_c  = sgn_c & bus.A[WIDTH-1];
    assign sb_c  = sgn_c & bus.B[WIDTH-1];
    assign a_mag = sa_c ? ('0 - bus.A) : bus.A;
    assign b_mag = sb_c ? ('0 - bus.B) : bus.B;

    // Shift-add step: upper half accumulates, multiplier shifts out of the bottom
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [PW-1:0]    mul_next, div_next, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign mul_sum   = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Restoring step: remainder in upper half, quotient bits enter at the bottom
    assign div_shift = {acc[PW-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[WIDTH-1:0] - opb;
    assign div_next  = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    assign prod_fix  = neg_q ? ('0 - acc) : acc;
    assign quo_fix   = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix   = neg_r ? ('0 - acc[PW-1:WIDTH]) : acc[PW-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            a_raw      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            b_zero     <= 1'b0;
            is_div     <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            alu_op     <= 4'b0000;
            illegal    <= 1'b0;
            mdu_result <= '0;
            mdu_valid  <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            illegal   <= 1'b0;
            mdu_valid <= 1'b0;
            div_zero  <= 1'b0;
            if (accept) begin
                alu_op  <= op_c;
                illegal <= illegal_c;
                if (mfhi_c) begin
                    mdu_result <= hi;
                    mdu_valid  <= 1'b1;
                end
                if (mflo_c) begin
                    mdu_result <= lo;
                    mdu_valid  <= 1'b1;
                end
                if (start_c) begin
                    acc    <= {{WIDTH{1'b0}}, a_mag};
                    opb    <= b_mag;
                    a_raw  <= bus.A;
                    neg_q  <= sa_c ^ sb_c;
                    neg_r  <= sa_c;
                    b_zero <= (bus.B == '0);
                    is_div <= bus.Funct[1];
                    cnt    <= CNT_W'(WIDTH);
                end
            end
            if (!flush) begin
                case (state)
                    S_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                    S_DIV: begin
                        acc <= div_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                    S_DONE: begin
                        if (!is_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (b_zero) begin
                            hi       <= a_raw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ALUOperation = alu_op;
    assign bus.Illegal      = illegal;
    assign bus.Stall        = stall;
    assign bus.Busy         = busy;
    assign bus.MduResult    = mdu_result;
    assign bus.MduValid     = mdu_valid;
    assign bus.DivZero      = div_zero;
endmodule

// File: tb/tb_alu_ctl_mdu.sv
// Self-checking bench for alu_ctl_mdu: decode table, MDU arithmetic, stall handshake,
// async reset abort, and (with MDU_FLUSH_EN) flush abort.
module tb_alu_ctl_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [3:0]  exp_op = 4'b0000;

    alu_ctl_mdu_if #(.WIDTH(32)) bus ();
    alu_ctl_mdu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.In_Valid = v;
        bus.ALUOp    = op;
        bus.Funct    = f;
        bus.A        = a;
        bus.B        = b;
    endtask

    // Reference decode table: {Illegal, ALUOperation}
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (op == 2'b11) return 5'b1_0000;
        case (f)
            6'd32: return 5'b0_0010;
            6'd34: return 5'b0_0110;
            6'd36: return 5'b0_0000;
            6'd37: return 5'b0_0001;
            6'd38: return 5'b0_0011;
            6'd39: return 5'b0_1100;
            6'd42: return 5'b0_0111;
            6'd43: return 5'b0_1111;
            6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27: return 5'b0_0000;
            default: return 5'b1_0000;
        endcase
    endfunction

    // Reference MDU arithmetic using wide native operators
    task automatic ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic signed [63:0] sx, sy;
        logic signed [31:0] sa, sb;
        logic [63:0] p;
        sa = a; sb = b; dz = 1'b0;
        sx = {{32{a[31]}}, a};
        sy = {{32{b[31]}}, b};
        if (f == 6'd24) begin
            p = sx * sy; hi = p[63:32]; lo = p[31:0];
        end else if (f == 6'd25) begin
            p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (f == 6'd26 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = 32'd0; lo = 32'h8000_0000;
        end else if (f == 6'd26) begin
            lo = sa / sb; hi = sa % sb;
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic test_reset();
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
`ifdef MDU_FLUSH_EN
        bus.Flush = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        n_total++; if (bus.ALUOperation !== 4'b0000) $display("FAIL reset_aluop got=%b exp=0000", bus.ALUOperation); else n_pass++;
        n_total++; if (bus.Illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", bus.Illegal); else n_pass++;
        n_total++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.Busy); else n_pass++;
        n_total++; if (bus.MduResult !== 32'd0) $display("FAIL reset_result got=%h exp=0", bus.MduResult); else n_pass++;
        n_total++; if (bus.MduValid !== 1'b0 || bus.DivZero !== 1'b0) $display("FAIL reset_pulses got=%b%b exp=00", bus.MduValid, bus.DivZero); else n_pass++;
        rst_n = 1'b1;
        step();
        issue(1'b1, 2'b10, 6'd16, 32'd0, 32'd0);
        step();
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        n_total++; if (bus.MduValid !== 1'b1 || bus.MduResult !== 32'd0) $display("FAIL reset_hi got=%b/%h exp=1/0", bus.MduValid, bus.MduResult); else n_pass++;
        step();
    endtask

    task automatic test_decode();
        logic [5:0] flist [10] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd16, 6'd18};
        logic v; logic [1:0] op; logic [5:0] f; logic [4:0] d; logic exp_ill, exp_mv;
        issue(1'b1, 2'b10, 6'd42, 32'd1, 32'd2);
        step();
        n_total++; if (bus.ALUOperation !== 4'b0111 || bus.Illegal !== 1'b0) $display("FAIL dec_slt got=%b/%b exp=0111/0", bus.ALUOperation, bus.Illegal); else n_pass++;
        issue(1'b1, 2'b11, 6'd42, 32'd1, 32'd2);
        step();
        n_total++; if (bus.ALUOperation !== 4'b0000 || bus.Illegal !== 1'b1) $display("FAIL dec_illegal got=%b/%b exp=0000/1", bus.ALUOperation, bus.Illegal); else n_pass++;
        issue(1'b0, 2'b11, 6'd42, 32'd1, 32'd2);
        step();
        n_total++; if (bus.ALUOperation !== 4'b0000 || bus.Illegal !== 1'b0) $display("FAIL dec_pulse got=%b/%b exp=0000/0", bus.ALUOperation, bus.Illegal); else n_pass++;
        exp_op = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            v  = 1'($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : flist[$urandom_range(0, 9)];
            if (op == 2'b10 && f >= 6'd24 && f <= 6'd27) f = 6'd0;
            issue(v, op, f, $urandom, $urandom);
            #1;
            n_total++; if (bus.Stall !== 1'b0) $display("FAIL dec_stall[%0d] got=%b exp=0", i, bus.Stall); else n_pass++;
            step();
            d = ref_dec(op, f);
            exp_ill = v & d[4];
            if (v) exp_op = d[3:0];
            exp_mv = v && op == 2'b10 && (f == 6'd16 || f == 6'd18);
            n_total++; if (bus.ALUOperation !== exp_op || bus.Illegal !== exp_ill) $display("FAIL dec_rand[%0d] op=%b f=%0d got=%b/%b exp=%b/%b", i, op, f, bus.ALUOperation, bus.Illegal, exp_op, exp_ill); else n_pass++;
            n_total++; if (bus.MduValid !== exp_mv || (exp_mv && bus.MduResult !== (f == 6'd16 ? m_hi : m_lo))) $display("FAIL dec_mdu[%0d] got=%b/%h exp=%b", i, bus.MduValid, bus.MduResult, exp_mv); else n_pass++;
        end
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_mdu_ops();
        logic [5:0]  fs [6] = '{6'd24, 6'd27, 6'd26, 6'd26, 6'd26, 6'd25};
        logic [31:0] as [6] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FF9C, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs [6] = '{32'd7, 32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [5:0] f; logic [31:0] a, b; logic dz; int n;
        for (int i = 0; i < 18; i++) begin
            if (i < 6) begin
                f = fs[i]; a = as[i]; b = bs[i];
            end else begin
                f = 6'(24 + $urandom_range(0, 3));
                a = $urandom;
                b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            end
            ref_mdu(f, a, b, m_hi, m_lo, dz);
            issue(1'b1, 2'b10, f, a, b);
            step();
            issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
            n_total++; if (bus.Busy !== 1'b1 || bus.ALUOperation !== 4'b0000) $display("FAIL mdu_start[%0d] busy=%b op=%b exp=1/0000", i, bus.Busy, bus.ALUOperation); else n_pass++;
            exp_op = 4'b0000;
            n = 0;
            while (bus.Busy === 1'b1 && n < 100) begin
                n++;
                step();
            end
            n_total++; if (n != 33) $display("FAIL mdu_busy_len[%0d] got=%0d exp=33", i, n); else n_pass++;
            n_total++; if (bus.DivZero !== dz) $display("FAIL mdu_divzero[%0d] got=%b exp=%b", i, bus.DivZero, dz); else n_pass++;
            issue(1'b1, 2'b10, 6'd16, 32'd0, 32'd0);
            step();
            n_total++; if (bus.MduValid !== 1'b1 || bus.MduResult !== m_hi) $display("FAIL mdu_hi[%0d] f=%0d a=%h b=%h got=%b/%h exp=1/%h", i, f, a, b, bus.MduValid, bus.MduResult, m_hi); else n_pass++;
            issue(1'b1, 2'b10, 6'd18, 32'd0, 32'd0);
            step();
            n_total++; if (bus.MduValid !== 1'b1 || bus.MduResult !== m_lo) $display("FAIL mdu_lo[%0d] f=%0d a=%h b=%h got=%b/%h exp=1/%h", i, f, a, b, bus.MduValid, bus.MduResult, m_lo); else n_pass++;
            issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
            step();
            n_total++; if (bus.MduValid !== 1'b0 || bus.DivZero !== 1'b0 || bus.MduResult !== m_lo) $display("FAIL mdu_idle[%0d] got=%b%b/%h exp=00/%h", i, bus.MduValid, bus.DivZero, bus.MduResult, m_lo); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2, b2, dh, dl; logic dz; int k;
        a2 = $urandom; b2 = $urandom;
        issue(1'b1, 2'b10, 6'd24, 32'd12345, 32'hFFFF_0000);
        step();
        issue(1'b1, 2'b00, 6'd0, 32'd0, 32'd0);
        #1;
        n_total++; if (bus.Stall !== 1'b0) $display("FAIL b2b_add_stall got=%b exp=0", bus.Stall); else n_pass++;
        step();
        n_total++; if (bus.ALUOperation !== 4'b0010) $display("FAIL b2b_add_op got=%b exp=0010", bus.ALUOperation); else n_pass++;
        issue(1'b1, 2'b10, 6'd25, a2, b2);
        #1;
        n_total++; if (bus.Stall !== 1'b1) $display("FAIL b2b_mult_held got=%b exp=1", bus.Stall); else n_pass++;
        k = 0;
        while (bus.Stall === 1'b1 && k < 200) begin step(); #1; k++; end
        n_total++; if (k >= 200 || bus.Busy !== 1'b0) $display("FAIL b2b_mult_release k=%0d busy=%b exp busy=0", k, bus.Busy); else n_pass++;
        ref_mdu(6'd25, a2, b2, dh, dl, dz);
        m_hi = dh; m_lo = dl;
        step();
        n_total++; if (bus.Busy !== 1'b1 || bus.ALUOperation !== 4'b0000) $display("FAIL b2b_mult2_start busy=%b op=%b exp=1/0000", bus.Busy, bus.ALUOperation); else n_pass++;
        issue(1'b1, 2'b10, 6'd16, 32'd0, 32'd0);
        k = 0;
        #1;
        while (bus.Stall === 1'b1 && k < 200) begin step(); #1; k++; end
        n_total++; if (k != 33) $display("FAIL b2b_mfhi_stall_cycles got=%0d exp=33", k); else n_pass++;
        step();
        n_total++; if (bus.MduValid !== 1'b1 || bus.MduResult !== m_hi) $display("FAIL b2b_mfhi got=%b/%h exp=1/%h", bus.MduValid, bus.MduResult, m_hi); else n_pass++;
        issue(1'b1, 2'b10, 6'd18, 32'd0, 32'd0);
        step();
        n_total++; if (bus.MduValid !== 1'b1 || bus.MduResult !== m_lo) $display("FAIL b2b_mflo got=%b/%h exp=1/%h", bus.MduValid, bus.MduResult, m_lo); else n_pass++;
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 2'b10, 6'd24, 32'hFFFF_FFFD, 32'd7);
        step();
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_total++; if (bus.Busy !== 1'b0 || bus.ALUOperation !== 4'b0000 || bus.Illegal !== 1'b0) $display("FAIL rstmid_ctl got=%b/%b/%b exp=0/0000/0", bus.Busy, bus.ALUOperation, bus.Illegal); else n_pass++;
        n_total++; if (bus.MduResult !== 32'd0 || bus.MduValid !== 1'b0 || bus.DivZero !== 1'b0) $display("FAIL rstmid_mdu got=%h/%b/%b exp=0/0/0", bus.MduResult, bus.MduValid, bus.DivZero); else n_pass++;
        step();
        rst_n = 1'b1;
        repeat (40) step();
        n_total++; if (bus.Busy !== 1'b0 || bus.DivZero !== 1'b0) $display("FAIL rstmid_abort got=%b/%b exp=0/0", bus.Busy, bus.DivZero); else n_pass++;
        issue(1'b1, 2'b10, 6'd16, 32'd0, 32'd0);
        step();
        n_total++; if (bus.MduResult !== 32'd0) $display("FAIL rstmid_hi got=%h exp=0", bus.MduResult); else n_pass++;
        issue(1'b1, 2'b10, 6'd18, 32'd0, 32'd0);
        step();
        n_total++; if (bus.MduResult !== 32'd0 || bus.MduValid !== 1'b1) $display("FAIL rstmid_lo got=%b/%h exp=1/0", bus.MduValid, bus.MduResult); else n_pass++;
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        step();
    endtask

`ifdef MDU_FLUSH_EN
    task automatic test_flush();
        int k;
        issue(1'b1, 2'b10, 6'd27, 32'd100, 32'd7);
        step();
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        k = 0;
        while (bus.Busy === 1'b1 && k < 100) begin step(); k++; end
        m_hi = 32'd2; m_lo = 32'd14;
        issue(1'b1, 2'b10, 6'd26, 32'd9, 32'd0);
        step();
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        repeat (5) step();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        n_total++; if (bus.Busy !== 1'b0 || bus.DivZero !== 1'b0) $display("FAIL flush_abort got=%b/%b exp=0/0", bus.Busy, bus.DivZero); else n_pass++;
        issue(1'b1, 2'b10, 6'd16, 32'd0, 32'd0);
        step();
        n_total++; if (bus.MduResult !== m_hi) $display("FAIL flush_hi got=%h exp=%h", bus.MduResult, m_hi); else n_pass++;
        issue(1'b1, 2'b10, 6'd18, 32'd0, 32'd0);
        step();
        n_total++; if (bus.MduResult !== m_lo) $display("FAIL flush_lo got=%h exp=%h", bus.MduResult, m_lo); else n_pass++;
        issue(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_mdu_ops();
        test_back_to_back();
`ifdef MDU_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
